// File: rtl/pipe_scroller.sv
// rtl/pipe_scroller.sv - scrolls pipe columns A/B with LFSR gap heights; SPEEDUP_EN enables the speed ramp
// Coordinates are y-up game space; every output is a direct register on gameClk.
module pipe_scroller #(
  parameter int          SCREEN_WIDTH = 640,
  parameter int          PIPE_WIDTH   = 60,
  parameter int          PIPE_SPACING = 360,
  parameter int          GAP_MIN      = 100,
  parameter int          GAP_RESET    = 240,
  parameter int          BIRD_X       = 160,
  parameter int          SPEED        = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        gameClk,
  input  logic        reset,
  input  logic        finished,
  output logic [10:0] Ax,
  output logic [10:0] Ay,
  output logic [10:0] Bx,
  output logic [10:0] By,
  output logic        passColumn,
  output logic [3:0]  speed
);

  localparam logic [10:0] X_RESET_A = 11'(SCREEN_WIDTH + PIPE_WIDTH);
  localparam logic [10:0] X_RESET_B = 11'(SCREEN_WIDTH + PIPE_WIDTH + PIPE_SPACING);
  localparam logic [10:0] X_PERIOD  = 11'(2 * PIPE_SPACING);
  localparam logic [10:0] GAP_BASE  = 11'(GAP_MIN);
  localparam logic [10:0] GAP_INIT  = 11'(GAP_RESET);
  localparam logic [10:0] BIRD_COL  = 11'(BIRD_X);

  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [10:0] spd;
  logic [10:0] new_gap;
  logic [10:0] ax_next;
  logic [10:0] bx_next;
  logic        a_wrap;
  logic        b_wrap;
  logic        a_pass;
  logic        b_pass;

  assign spd       = {7'd0, speed};
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign new_gap   = GAP_BASE + {3'd0, lfsr[7:0]};

  // A pipe that would scroll past the left edge re-enters one full period to the right.
  assign a_wrap  = Ax <= spd;
  assign b_wrap  = Bx <= spd;
  assign ax_next = a_wrap ? (Ax + X_PERIOD - spd) : (Ax - spd);
  assign bx_next = b_wrap ? (Bx + X_PERIOD - spd) : (Bx - spd);

  assign a_pass = (Ax >= BIRD_COL) && ((Ax - spd) < BIRD_COL);
  assign b_pass = (Bx >= BIRD_COL) && ((Bx - spd) < BIRD_COL);

  always_ff @(posedge gameClk) begin
    if (reset) begin
      Ax         <= X_RESET_A;
      Bx         <= X_RESET_B;
      Ay         <= GAP_INIT;
      By         <= GAP_INIT;
      passColumn <= 1'b0;
      lfsr       <= LFSR_SEED;
    end else begin
      // The LFSR keeps running while frozen so the gap sequence depends on game-over time.
      lfsr <= lfsr_next;
      if (finished) begin
        passColumn <= 1'b0;
      end else begin
        Ax         <= ax_next;
        Bx         <= bx_next;
        passColumn <= a_pass || b_pass;
        if (a_wrap) Ay <= new_gap;
        if (b_wrap) By <= new_gap;
      end
    end
  end

`ifdef SPEEDUP_EN
  logic [3:0] pass_cnt;

  // Every fifth pass bumps the speed, saturating at 6.
  always_ff @(posedge gameClk) begin
    if (reset) begin
      pass_cnt <= 4'd0;
      speed    <= 4'(SPEED);
    end else if (!finished && passColumn) begin
      if (pass_cnt == 4'd4) begin
        pass_cnt <= 4'd0;
        if (speed < 4'd6) speed <= speed + 4'd1;
      end else begin
        pass_cnt <= pass_cnt + 4'd1;
      end
    end
  end
`else
  assign speed = 4'(SPEED);
`endif

endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
Generates and scrolls the two pipe columns (A, B) for the flappy-bird game on the game clock. Produces the pipe x/gap-y coordinates in y-up game space and a one-cycle pass pulse. It sits upstream of collision detection, the VGA renderer (after y-flip) and score calculation. Movement freezes while the game is finished.

Parameters:
SCREEN_WIDTH, 640, visible width in pixels
PIPE_WIDTH, 60, pipe width in pixels
PIPE_SPACING, 360, x distance between A and B; 2*PIPE_SPACING must be >= SCREEN_WIDTH+PIPE_WIDTH
GAP_MIN, 100, minimum gap-centre y
GAP_RESET, 240, gap-centre y loaded at reset
BIRD_X, 160, bird x column used for pass detection
SPEED, 2, scroll pixels per gameClk cycle (1..15)
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
gameClk  input  1  game tick clock
reset  input  1  synchronous, active-high reset
finished  input  1  game over; freezes scrolling
Ax  output  11  pipe A right-edge x; pipe spans [Ax-PIPE_WIDTH, Ax)
Ay  output  11  pipe A gap-centre y, y-up
Bx  output  11  pipe B right-edge x
By  output  11  pipe B gap-centre y
passColumn  output  1  one-cycle pulse when a pipe right edge crosses BIRD_X
speed  output  4  current scroll speed

Behaviour:
- One clock (gameClk). Reset is synchronous and active-high, sampled on the gameClk edge. Reset has priority over everything, including finished.
- Reset values: Ax=SCREEN_WIDTH+PIPE_WIDTH (700), Bx=Ax+PIPE_SPACING (1060), Ay=By=GAP_RESET (240), passColumn=0, speed=SPEED, lfsr=LFSR_SEED.
- LFSR: 16-bit Galois, taps mask 16'hB400, shift right. It advances every non-reset cycle, including while finished.
- Per pipe P in {A,B}, each cycle with finished=0:
  - If Px <= speed (wrap): Px <= Px + 2*PIPE_SPACING - speed, and Py <= GAP_MIN + lfsr[7:0] using the current (pre-advance) lfsr value. The result is in 100..355.
  - Otherwise: Px <= Px - speed, and Py holds.
- Spacing invariant: Bx-Ax ≡ ±PIPE_SPACING at all times. A and B never wrap in the same cycle.
- passColumn is registered and is high in the same cycle the new Px becomes visible:
  - passColumn <= !finished && ((Ax >= BIRD_X && Ax-speed < BIRD_X) || (same term for B)).
  - Wrap cycles never assert it.
  - It is never high on two consecutive cycles.
- finished=1: Ax/Ay/Bx/By/speed hold, and passColumn is 0 the next cycle. When finished deasserts, scrolling resumes from the held values with no skipped step.
- All arithmetic is 11-bit unsigned. The maximum x value is 1060, so there is no overflow.
- Zero latency to the consumer: outputs are direct registers, updated one gameClk edge after the inputs are sampled.

Optional Feature:
SPEEDUP_EN:
- Defined: a 4-bit pass counter increments on each passColumn pulse. When it reaches 5 it clears and speed increments by 1, saturating at 6. The speed change takes effect on the cycle after the pulse. Wrap and pass tests use the current speed. Reset clears the counter and sets speed=SPEED. finished freezes the counter.
- Undefined: the counter does not exist, and speed is the constant SPEED.

Test Plan:
1. Reset: assert reset 2 cycles -> Ax=700, Bx=1060, Ay=By=240, passColumn=0, speed=2.
2. Scroll: release reset, run 10 cycles -> Ax=680, Bx=1040, Ay/By=240, passColumn=0 throughout.
3. Pass: run from reset -> passColumn high only on cycle 271 (Ax=158); low on cycles 270 and 272. Pipe B passes on cycle 451 (Bx=158).
4. Wrap: cycle 349 Ax=2 -> cycle 350 Ax=720, Bx=360, Ay=100+lfsr[7:0] matching a software Galois model seeded 0xACE1. No passColumn on the wrap cycle.
5. Freeze: assert finished at cycle 270 for 20 cycles -> all coordinates hold at Ax=160, and no pulse. Deassert -> next cycle Ax=158 with passColumn=1.
6. Reset mid-run: at cycle 400 assert reset together with finished=1 -> next cycle shows reset values. Rerunning reproduces an identical gap sequence. With SPEEDUP_EN defined, speed=3 the cycle after the 5th pulse, and it saturates at 6.
